// File: rtl/dft_twiddle_gen.sv
// rtl/dft_twiddle_gen.sv - twiddle-factor stream W = exp(-j*2*pi*m/N), m = k*step mod N
// Optional conjugation (IDFT) enabled by defining DFT_TWIDDLE_INV_EN.
module dft_twiddle_gen #(
    parameter int DATA_W   = 16,
    parameter int N_LOG2   = 10,
    parameter     ROM_FILE = "twiddle_q15.hex"
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_LOG2-1:0] step,
    input  logic [N_LOG2:0]   count,
    input  logic              inv,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] tw_re,
    output logic [DATA_W-1:0] tw_im,
    output logic [N_LOG2-1:0] tw_index,
    output logic              tw_last,
    output logic              tw_valid,
    input  logic              tw_ready
);

    localparam int N  = 1 << N_LOG2;
    localparam int QN = N / 4;
    localparam int AW = N_LOG2 - 1;

    // Quarter-wave table is generated at elaboration with the same rounding the hex image uses.
    localparam int unused_rom_file_bits = $bits(ROM_FILE);

    function automatic logic signed [DATA_W-1:0] tcos(input int i);
        longint x, term, sum, v;
        x    = (64'sd6746518852 * longint'(i)) / longint'(N);
        term = 64'sd1 <<< 30;
        sum  = term;
        for (int k = 1; k <= 12; k++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / longint'(2 * k * (2 * k - 1));
            sum  = sum + term;
        end
        v = (sum * 64'sd32768 + (64'sd1 <<< 29)) >>> 30;
        if (v > 64'sd32767) v = 64'sd32767;
        if (v < 64'sd0) v = 64'sd0;
        return DATA_W'(v);
    endfunction

    logic signed [DATA_W-1:0] rom [0:QN];
    for (genvar g = 0; g <= QN; g++) begin : g_rom
        localparam logic signed [DATA_W-1:0] TV = tcos(g);
        assign rom[g] = TV;
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t state, state_nx;

    logic [N_LOG2-1:0] step_q, acc;
    logic [N_LOG2:0]   count_q, issued;
    logic              adv, issue, issue_last;

    assign adv        = !(tw_valid && !tw_ready);
    assign issue_last = (issued == count_q - 1'b1);

    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE:    if (start && count != '0) state_nx = RUN;
            RUN: begin
                if (adv) begin
                    issue = 1'b1;
                    if (issue_last) state_nx = DRAIN;
                end
            end
            DRAIN:   if (tw_valid && tw_ready && tw_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            step_q  <= '0;
            count_q <= '0;
            acc     <= '0;
            issued  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            if (state == IDLE && start) begin
                if (count == '0) begin
                    done <= 1'b1;
                end else begin
                    step_q  <= step;
                    count_q <= count;
                    acc     <= '0;
                    issued  <= '0;
                    busy    <= 1'b1;
                end
            end
            if (issue) begin
                acc    <= acc + step_q;
                issued <= issued + 1'b1;
            end
            if (state == DRAIN && state_nx == IDLE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

`ifdef DFT_TWIDDLE_INV_EN
    logic inv_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inv_q <= 1'b0;
        else if (state == IDLE && start && count != '0) inv_q <= inv;
    end
`else
    logic unused_inv;
    assign unused_inv = inv;
`endif

    logic                     s1_v, s1_last, s2_v, s2_last;
    logic [1:0]               s1_q, s2_q;
    logic [AW-1:0]            s1_a0, s1_a1;
    logic [N_LOG2-1:0]        s1_m, s2_m;
    logic signed [DATA_W-1:0] s2_a, s2_b, cos_v, sin_v, im_v;

    always_comb begin
        cos_v = s2_a;
        sin_v = s2_b;
        case (s2_q)
            2'd1:    begin cos_v = -s2_b; sin_v =  s2_a; end
            2'd2:    begin cos_v = -s2_a; sin_v = -s2_b; end
            2'd3:    begin cos_v =  s2_b; sin_v = -s2_a; end
            default: ;
        endcase
`ifdef DFT_TWIDDLE_INV_EN
        im_v = inv_q ? sin_v : -sin_v;
`else
        im_v = -sin_v;
`endif
    end

    // Whole pipe freezes together on a stall, so index/last stay aligned with their data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v <= 1'b0; s1_last <= 1'b0; s1_q <= '0; s1_a0 <= '0; s1_a1 <= '0; s1_m <= '0;
            s2_v <= 1'b0; s2_last <= 1'b0; s2_q <= '0; s2_a <= '0; s2_b <= '0; s2_m <= '0;
            tw_valid <= 1'b0; tw_last <= 1'b0; tw_index <= '0; tw_re <= '0; tw_im <= '0;
        end else if (adv) begin
            s1_v     <= issue;
            s1_last  <= issue && issue_last;
            s1_m     <= acc;
            s1_q     <= acc[N_LOG2-1 -: 2];
            s1_a0    <= {1'b0, acc[N_LOG2-3:0]};
            s1_a1    <= AW'(QN) - {1'b0, acc[N_LOG2-3:0]};
            s2_v     <= s1_v;
            s2_last  <= s1_last;
            s2_m     <= s1_m;
            s2_q     <= s1_q;
            s2_a     <= rom[s1_a0];
            s2_b     <= rom[s1_a1];
            tw_valid <= s2_v;
            tw_last  <= s2_v && s2_last;
            tw_index <= s2_m;
            tw_re    <= cos_v;
            tw_im    <= im_v;
        end
    end

endmodule

// File: tb/tb_dft_twiddle_gen.sv
// tb/tb_dft_twiddle_gen.sv - self-checking bench for dft_twiddle_gen (N_LOG2=4)
module tb_dft_twiddle_gen;

    localparam int  NL = 4;
    localparam int  N  = 16;
    localparam real PI = 3.14159265358979;

    logic               clk, rst_n, start, inv, tw_ready;
    logic [NL-1:0]      step;
    logic [NL:0]        count;
    logic               busy, done, tw_last, tw_valid;
    logic signed [15:0] tw_re, tw_im;
    logic [NL-1:0]      tw_index;

    dft_twiddle_gen #(.DATA_W(16), .N_LOG2(NL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step(step), .count(count), .inv(inv),
        .busy(busy), .done(done), .tw_re(tw_re), .tw_im(tw_im), .tw_index(tw_index),
        .tw_last(tw_last), .tw_valid(tw_valid), .tw_ready(tw_ready)
    );

    typedef struct {int m; bit last;} ent_t;

    int   checks = 0, failures = 0, cyc = 0;
    ent_t exp_q[$];
    int   seen_idx[$];
    bit   run_inv, ready_mode;
    int   start_cyc, first_vcyc, last_vcyc, vcnt, last_idx;
    bit   c_stalled, c_last_hs;
    logic signed [15:0] h_re, h_im;
    logic [NL-1:0]      h_idx;
    logic               h_last;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        int pc;
        pc = 0;
        tw_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode) begin
                tw_ready = (pc % 4 == 0) || (pc % 4 == 3);
                pc++;
            end else begin
                tw_ready = 1'b1;
            end
        end
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int qround(input real x);
        int v;
        v = int'($floor(x * 32768.0 + 0.5));
        if (v > 32767) v = 32767;
        if (v < -32767) v = -32767;
        return v;
    endfunction

    function automatic int gold_re(input int m);
        return qround($cos(2.0 * PI * real'(m) / real'(N)));
    endfunction

    function automatic int gold_im(input int m, input bit conj);
        int s;
        s = qround($sin(2.0 * PI * real'(m) / real'(N)));
        return conj ? s : -s;
    endfunction

    function automatic bit pin(input int m, output int re, output int im);
        pin = 1'b1;
        case (m)
            0:       begin re = 32767;  im = 0;      end
            2:       begin re = 23170;  im = -23170; end
            4:       begin re = 0;      im = -32767; end
            8:       begin re = -32767; im = 0;      end
            12:      begin re = 0;      im = 32767;  end
            default: begin re = 0; im = 0; pin = 1'b0; end
        endcase
    endfunction

    function automatic bit eff_inv();
`ifdef DFT_TWIDDLE_INV_EN
        return run_inv;
`else
        return 1'b0;
`endif
    endfunction

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            c_stalled = 1'b0;
            c_last_hs = 1'b0;
        end else begin
            if (c_last_hs) begin
                chk(done === 1'b1, "done_after_last", done, 1);
                chk(busy === 1'b0, "busy_falls_with_done", busy, 0);
            end
            c_last_hs = 1'b0;
            if (c_stalled) begin
                chk(tw_valid === 1'b1, "valid_held_in_stall", tw_valid, 1);
                chk({tw_re, tw_im, tw_index, tw_last} === {h_re, h_im, h_idx, h_last},
                    "stable_in_stall", tw_index, h_idx);
            end
            if (tw_valid === 1'b1) begin
                vcnt++;
                if (first_vcyc < 0) first_vcyc = cyc;
                last_vcyc = cyc;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_valid", tw_index, -1);
                end else begin
                    int m, gre, gim, pre, pim;
                    m   = exp_q[0].m;
                    gre = gold_re(m);
                    gim = gold_im(m, eff_inv());
                    chk(int'(tw_index) == m, "index", tw_index, m);
                    chk(tw_last === exp_q[0].last, "last_flag", tw_last, exp_q[0].last);
                    chk(int'(tw_re) - gre <= 1 && gre - int'(tw_re) <= 1, "re_vs_model", tw_re, gre);
                    chk(int'(tw_im) - gim <= 1 && gim - int'(tw_im) <= 1, "im_vs_model", tw_im, gim);
                    if (pin(m, pre, pim)) begin
                        if (eff_inv()) pim = -pim;
                        chk(int'(tw_re) == pre, "pinned_re", tw_re, pre);
                        chk(int'(tw_im) == pim, "pinned_im", tw_im, pim);
                    end
                    if (tw_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        seen_idx.push_back(int'(tw_index));
                        if (tw_last === 1'b1) begin
                            c_last_hs = 1'b1;
                            last_idx  = int'(tw_index);
                        end
                    end
                end
            end
            c_stalled = (tw_valid === 1'b1) && (tw_ready !== 1'b1);
            h_re = tw_re; h_im = tw_im; h_idx = tw_index; h_last = tw_last;
        end
    end

    task automatic go(input int st, input int c, input bit iv);
        @(posedge clk);
        #1;
        step = NL'(st); count = (NL+1)'(c); inv = iv; start = 1'b1;
        start_cyc = cyc; run_inv = iv;
        vcnt = 0; first_vcyc = -1; last_vcyc = -1;
        seen_idx.delete();
        for (int k = 0; k < c; k++) begin
            ent_t e;
            e.m    = (k * st) % N;
            e.last = (k == c - 1);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) chk(1'b0, "done_timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk(tw_re === '0,    {tag, "_re"},    tw_re, 0);
        chk(tw_im === '0,    {tag, "_im"},    tw_im, 0);
        chk(tw_index === '0, {tag, "_index"}, tw_index, 0);
        chk(tw_valid === 0,  {tag, "_valid"}, tw_valid, 0);
        chk(tw_last === 0,   {tag, "_last"},  tw_last, 0);
        chk(busy === 0,      {tag, "_busy"},  busy, 0);
        chk(done === 0,      {tag, "_done"},  done, 0);
    endtask

    initial begin
        int dc, first;
        int exp_b[8];
        exp_b = '{0, 5, 10, 15, 4, 9, 14, 3};
        rst_n = 1'b0; start = 1'b0; step = '0; count = '0; inv = 1'b0; ready_mode = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        go(1, 16, 1'b0);
        wait_done(80, dc);
        chk(first_vcyc - start_cyc == 4, "first_valid_latency", first_vcyc - start_cyc, 4);
        chk(vcnt == 16, "valid_cycles", vcnt, 16);
        chk(last_vcyc - first_vcyc == 15, "valid_consecutive", last_vcyc - first_vcyc, 15);
        chk(dc - start_cyc == 20, "done_latency", dc - start_cyc, 20);
        chk(exp_q.size() == 0, "run_a_drained", exp_q.size(), 0);

        go(5, 8, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        step = 4'd3; count = 5'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(80, dc);
        chk(seen_idx.size() == 8, "step5_count", seen_idx.size(), 8);
        for (int i = 0; i < 8 && i < seen_idx.size(); i++)
            chk(seen_idx[i] == exp_b[i], "step5_index_seq", seen_idx[i], exp_b[i]);
        chk(last_idx == 3, "step5_last_index", last_idx, 3);
        repeat (8) @(negedge clk);
        chk(busy === 1'b0, "ignored_start_no_rerun", busy, 0);

        ready_mode = 1'b1;
        go(3, 16, 1'b0);
        wait_done(300, dc);
        chk(seen_idx.size() == 16, "stall_run_count", seen_idx.size(), 16);
        ready_mode = 1'b0;
        repeat (2) @(posedge clk);

        go(2, 0, 1'b0);
        @(negedge clk);
        chk(done === 1'b1, "zero_count_done", done, 1);
        chk(busy === 1'b0, "zero_count_busy", busy, 0);
        repeat (6) begin
            @(negedge clk);
            chk(busy === 1'b0 && tw_valid === 1'b0 && done === 1'b0, "zero_count_idle", busy, 0);
        end

        go(4, 4, 1'b1);
        wait_done(80, dc);
        chk(seen_idx.size() == 4, "inv_run_count", seen_idx.size(), 4);

        go(1, 16, 1'b0);
        first = 0;
        while (tw_valid !== 1'b1 && first < 20) begin
            @(negedge clk);
            first++;
        end
        chk(tw_valid === 1'b1, "valid_before_reset", tw_valid, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_zero("midrun_reset");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        go(2, 4, 1'b0);
        wait_done(80, dc);
        first = (seen_idx.size() > 0) ? seen_idx[0] : -1;
        chk(seen_idx.size() == 4, "restart_count", seen_idx.size(), 4);
        chk(first == 0, "restart_first_index", first, 0);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
